// File: rtl/interboard_tx_arbiter_pkg.sv
// Shared definitions for the interboard transmit path: message layout and
// arbiter FSM state encodings.
package interboard_tx_arbiter_pkg;

  localparam int MSG_W = 23;

  // Field order is MSB first and must match the peer board's unpacker.
  typedef struct packed {
    logic       en;        // [22]
    logic       move_dir;  // [21]
    logic [4:0] block_x;   // [20:16]
    logic [2:0] block_y;   // [15:13]
    logic [3:0] msg_type;  // [12:9]
    logic [5:0] card;      // [8:3]
    logic [2:0] sel_len;   // [2:0]
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/interboard_msg_fifo.sv
// Ctrl-message FIFO: DEPTH entries (power of two, at least 2), pointers wrap
// modulo DEPTH, occupancy counter bounded to 0..DEPTH.
module interboard_msg_fifo
  import interboard_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = MSG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/interboard_tx_arbiter.sv
// Arbitrates GameControl and system messages onto the interboard link, with
// acknowledge timeout, bounded retries and a sticky link-failure state.
module interboard_tx_arbiter
  import interboard_tx_arbiter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 1000000,
  parameter int MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_valid,
  input  logic [MSG_W-1:0]       ctrl_msg,
  output logic                   ctrl_ready,
  input  logic                   sys_valid,
  input  logic [MSG_W-1:0]       sys_msg,
  output logic                   sys_ready,
  output logic                   tx_start,
  output logic [MSG_W-1:0]       tx_msg,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] q_cnt,
  output logic                   idle,
  output logic                   link_err,
  output state_e                 dbg_state
);

  // Handshake: a message transfers on a rising clk edge where valid && ready.
  // Readys depend on registered state only, so a full FIFO never accepts in
  // the same cycle that it pops.

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e           state_q, state_d;
  msg_t             tx_msg_q, tx_msg_d;
  logic             src_sys_q, src_sys_d;
  logic             sys_pend_q, sys_pend_d;
  msg_t             sys_msg_q, sys_msg_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             tx_start_q, tx_start_d;
  logic             link_err_q, link_err_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [MSG_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             sys_clr;

  interboard_msg_fifo #(
    .DEPTH (DEPTH),
    .W     (MSG_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (ctrl_msg),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_cnt)
  );

  assign ctrl_ready = !fifo_full && (state_q != ST_ERR);
  assign sys_ready  = !sys_pend_q && (state_q != ST_ERR);
  assign fifo_push  = ctrl_valid && ctrl_ready;
  assign idle       = (state_q == ST_IDLE) && fifo_empty && !sys_pend_q;

  assign tx_start  = tx_start_q;
  assign tx_msg    = tx_msg_q;
  assign link_err  = link_err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    tx_msg_d  = tx_msg_q;
    src_sys_d = src_sys_q;
    retry_d   = retry_q;
    to_cnt_d  = to_cnt_q;
    fifo_pop  = 1'b0;
    sys_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_pend_q) begin
          tx_msg_d  = sys_msg_q;
          src_sys_d = 1'b1;
          state_d   = ST_SEND;
        end else if (!fifo_empty) begin
          tx_msg_d  = fifo_head;
          src_sys_d = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // An acknowledge on the timeout cycle still counts as success.
        if (tx_done) begin
          if (src_sys_q) sys_clr  = 1'b1;
          else           fifo_pop = 1'b1;
          retry_d  = '0;
          to_cnt_d = '0;
          state_d  = ST_IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          to_cnt_d = '0;
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            state_d = ST_SEND;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sys_pend_d = sys_pend_q;
    sys_msg_d  = sys_msg_q;
    if (sys_clr) sys_pend_d = 1'b0;
    if (sys_valid && sys_ready) begin
      sys_pend_d = 1'b1;
      sys_msg_d  = sys_msg;
    end
  end

  // tx_start is registered from the next state so it is high exactly while
  // the FSM sits in SEND.
  always_comb begin
    tx_start_d = (state_d == ST_SEND);
    link_err_d = link_err_q || (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tx_msg_q   <= '0;
      src_sys_q  <= 1'b0;
      sys_pend_q <= 1'b0;
      sys_msg_q  <= '0;
      retry_q    <= '0;
      to_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      link_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_msg_q   <= tx_msg_d;
      src_sys_q  <= src_sys_d;
      sys_pend_q <= sys_pend_d;
      sys_msg_q  <= sys_msg_d;
      retry_q    <= retry_d;
      to_cnt_q   <= to_cnt_d;
      tx_start_q <= tx_start_d;
      link_err_q <= link_err_d;
    end
  end

endmodule

// File: doc/interboard_tx_arbiter.md
INTERBOARD_TX_ARBITER -- requirements
Module: interboard_tx_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 4, ctrl FIFO entries (power of two).
- TIMEOUT, 1000000, cycles allowed in WAIT before a retry (10 ms at 100 MHz).
- MAX_RETRY, 3, resends before the link is declared failed.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous, active-low reset.
- ctrl_valid, in, 1, GameControl message offered.
- ctrl_msg, in, 23, packed GameControl message.
- ctrl_ready, out, 1, ctrl message accepted when valid&ready.
- sys_valid, in, 1, system message offered (table reset / sync).
- sys_msg, in, 23, packed system message.
- sys_ready, out, 1, sys message accepted when valid&ready.
- tx_start, out, 1, one-cycle pulse to InterboardCommunication.
- tx_msg, out, 23, message under transmission.
- tx_done, in, 1, one-cycle pulse from the link when the peer acknowledged.
- q_cnt, out, 3, ctrl FIFO occupancy (0..DEPTH).
- idle, out, 1, high in IDLE with FIFO empty and no sys pending.
- link_err, out, 1, sticky link-failure flag.
REQ-003 Message packing, MSB to LSB: en[22], move_dir[21], block_x[20:16], block_y[15:13], msg_type[12:9], card[8:3], sel_len[2:0].

Function
REQ-004 Ctrl messages SHALL enter a DEPTH-entry FIFO; ctrl_ready = (q_cnt<DEPTH) && state!=ERR, computed from registered state only, with no same-cycle pop bypass.
REQ-005 Sys messages SHALL enter a one-entry holding register; sys_ready = !sys_pend && state!=ERR.
REQ-006 FSM states SHALL be IDLE, SEND, WAIT, ERR.
REQ-007 In IDLE, a pending sys message SHALL take priority over the FIFO head. The selected message latches into tx_msg, the source bit is recorded, and the FSM moves to SEND.
REQ-008 SEND SHALL last exactly one cycle: tx_start=1, then WAIT. tx_msg SHALL stay stable from SEND until the FSM leaves WAIT.
REQ-009 In WAIT, tx_done SHALL:
- free the source (FIFO pop or sys_pend clear);
- clear the retry and timeout counters;
- return the FSM to IDLE.
REQ-010 The minimum spacing between consecutive tx_start pulses SHALL be 3 cycles (SEND, WAIT, IDLE).
REQ-011 The timeout counter SHALL increment every WAIT cycle. When it reaches TIMEOUT-1 without tx_done:
- if retry_cnt<MAX_RETRY: retry_cnt+1, return to SEND with the same tx_msg;
- otherwise: go to ERR.
REQ-012 tx_done outside WAIT SHALL be ignored. tx_done on the timeout cycle SHALL win, i.e. be treated as success.
REQ-013 A sys message arriving while a ctrl message is in WAIT SHALL NOT preempt it; it is served at the next IDLE.
REQ-014 ERR SHALL:
- hold link_err=1;
- hold tx_start=0;
- hold both readys at 0;
- be left only by reset.
REQ-015 All counters SHALL saturate or be bounded, with no wrap. FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-016 Outputs SHALL be registered except ctrl_ready, sys_ready and idle, which are decoded from registered state.

Reset
REQ-017 While rst=0, the block SHALL asynchronously hold:
- state=IDLE;
- q_cnt=0 and FIFO pointers=0;
- sys_pend=0;
- retry_cnt=0 and timeout counter=0;
- tx_start=0, tx_msg=0, link_err=0.
REQ-018 Reset mid-WAIT SHALL discard the in-flight message and all queued messages; no tx_start is issued on the first cycle after release.

Structure
REQ-019 The message width (23), field offsets, and FSM state encodings SHALL live in the shared interboard package.
REQ-020 The FIFO SHALL be one sub-module, interboard_msg_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-021 Single ctrl message 0x5A5A5A, tx_done 10 cycles after tx_start -> exactly one tx_start with tx_msg=0x5A5A5A, then q_cnt=0 and idle=1.
REQ-022 Four ctrl messages pushed back to back, plus a fifth attempt -> ctrl_ready=0 on the fifth, q_cnt=4, and the four messages are sent in FIFO order.
REQ-023 Ctrl message in WAIT, then sys message 0x400001 pushed -> the ctrl message completes first, then sys is sent before the next ctrl entry.
REQ-024 tx_done never asserted (TIMEOUT=16) -> 4 tx_start pulses 17 cycles apart carrying the same tx_msg, then link_err=1 and both readys=0.
REQ-025 rst low during WAIT with q_cnt=3, then released -> q_cnt=0, tx_start=0, idle=1, link_err=0.
REQ-026 tx_done pulse in IDLE, and tx_done on the timeout cycle -> the first is ignored, the second is counted as success with no retry.
